// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: phase FSM, game/ready timer, mole spawn and lifetime,
// hit/miss counters and difficulty level. All outputs are registered.
module mole_round_scheduler #(
    parameter int unsigned GAME_TIME  = 60,
    parameter int unsigned READY_TIME = 3,
    parameter int unsigned LIFE_INIT  = 20,
    parameter int unsigned LIFE_MIN   = 5,
    parameter int unsigned LIFE_DEC   = 2,
    parameter int unsigned LEVEL_HITS = 5,
    parameter int unsigned GAP_TICKS  = 2,
    parameter int unsigned MAX_MISS   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick_sec,
    input  logic       tick_step,
    input  logic       hit,
    input  logic [1:0] rand_row,
    input  logic [1:0] rand_col,
    output logic [1:0] phase,
    output logic       is_started,
    output logic       mole_valid,
    output logic [1:0] mole_row,
    output logic [1:0] mole_col,
    output logic       hit_ack,
    output logic [6:0] time_left,
    output logic [9:0] hit_count,
    output logic [6:0] miss_count,
    output logic [3:0] level
);
    typedef enum logic [2:0] {S_IDLE, S_READY, S_SPAWN, S_UP, S_GAP, S_OVER} state_t;

    localparam int unsigned LW  = $clog2(LIFE_INIT + 1);
    localparam int unsigned GW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int unsigned LHW = $clog2(LEVEL_HITS + 1);

    state_t         state_reg;
    logic           start_prev_reg;
    logic [LW-1:0]  life_cnt_reg;
    logic [GW-1:0]  gap_cnt_reg;
    logic [LHW-1:0] lvl_hits_reg;

    logic           start_evt;
    logic           in_play;
    logic [31:0]    dec_total;
    logic [31:0]    cur_life;
    logic [1:0]     spawn_col;
    logic [LHW-1:0] lvl_hits_inc;
    logic           level_up;
    logic [9:0]     hit_count_next;
    logic [6:0]     miss_count_next;
    logic [3:0]     level_next;

    assign start_evt = start_prev_reg & ~start;
    assign in_play   = (state_reg == S_SPAWN) || (state_reg == S_UP) || (state_reg == S_GAP);

    // Clamp to LIFE_MIN before subtracting so high levels never wrap.
    assign dec_total = LIFE_DEC * 32'(level);
    assign cur_life  = (dec_total + LIFE_MIN >= LIFE_INIT) ? LIFE_MIN : (LIFE_INIT - dec_total);

    // Never respawn on the same hole twice in a row.
    assign spawn_col = ({rand_row, rand_col} == {mole_row, mole_col}) ? rand_col + 2'd1 : rand_col;

    assign lvl_hits_inc    = lvl_hits_reg + LHW'(1);
    assign level_up        = (lvl_hits_inc == LHW'(LEVEL_HITS));
    assign hit_count_next  = (hit_count == 10'd999) ? 10'd999 : hit_count + 10'd1;
    assign miss_count_next = (miss_count == 7'd99) ? 7'd99 : miss_count + 7'd1;
    assign level_next      = (level == 4'd15) ? 4'd15 : level + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            start_prev_reg <= 1'b1;
            life_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            lvl_hits_reg   <= '0;
            phase          <= 2'd0;
            is_started     <= 1'b0;
            mole_valid     <= 1'b0;
            mole_row       <= 2'd0;
            mole_col       <= 2'd0;
            hit_ack        <= 1'b0;
            time_left      <= 7'(GAME_TIME);
            hit_count      <= 10'd0;
            miss_count     <= 7'd0;
            level          <= 4'd0;
        end else begin
            start_prev_reg <= start;
            hit_ack        <= 1'b0;
            case (state_reg)
                S_IDLE, S_OVER: begin
                    if (start_evt) begin
                        state_reg    <= S_READY;
                        phase        <= 2'd1;
                        time_left    <= 7'(READY_TIME);
                        hit_count    <= 10'd0;
                        miss_count   <= 7'd0;
                        level        <= 4'd0;
                        lvl_hits_reg <= '0;
                    end
                end
                S_READY: begin
                    if (tick_sec) begin
                        if (time_left == 7'd1) begin
                            state_reg  <= S_SPAWN;
                            phase      <= 2'd2;
                            is_started <= 1'b1;
                            time_left  <= 7'(GAME_TIME);
                        end else begin
                            time_left <= time_left - 7'd1;
                        end
                    end
                end
                S_SPAWN: begin
                    mole_row     <= rand_row;
                    mole_col     <= spawn_col;
                    life_cnt_reg <= LW'(cur_life);
                    mole_valid   <= 1'b1;
                    state_reg    <= S_UP;
                end
                S_UP: begin
                    if (hit) begin
                        // A hit takes precedence over an expiry landing in the same cycle.
                        hit_ack     <= 1'b1;
                        hit_count   <= hit_count_next;
                        mole_valid  <= 1'b0;
                        gap_cnt_reg <= GW'(GAP_TICKS);
                        state_reg   <= S_GAP;
                        if (level_up) begin
                            lvl_hits_reg <= '0;
                            level        <= level_next;
                        end else begin
                            lvl_hits_reg <= lvl_hits_inc;
                        end
                    end else if (tick_step) begin
                        if (life_cnt_reg == LW'(1)) begin
                            miss_count  <= miss_count_next;
                            mole_valid  <= 1'b0;
                            gap_cnt_reg <= GW'(GAP_TICKS);
                            if (MAX_MISS != 0 && miss_count_next == 7'(MAX_MISS)) begin
                                state_reg  <= S_OVER;
                                phase      <= 2'd3;
                                is_started <= 1'b0;
                            end else begin
                                state_reg <= S_GAP;
                            end
                        end else begin
                            life_cnt_reg <= life_cnt_reg - LW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg <= S_SPAWN;
                    end else if (tick_step) begin
                        gap_cnt_reg <= gap_cnt_reg - GW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // Game clock runs across SPAWN/UP/GAP; expiry overrides any transition above.
            if (in_play && tick_sec) begin
                if (time_left == 7'd1) begin
                    state_reg  <= S_OVER;
                    phase      <= 2'd3;
                    is_started <= 1'b0;
                    mole_valid <= 1'b0;
                    time_left  <= 7'd0;
                end else begin
                    time_left <= time_left - 7'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler: phases, timers, mole lifetime, levels, misses, reset.
module tb_mole_round_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b1;
    logic       tick_sec = 1'b0;
    logic       tick_step = 1'b0;
    logic       hit = 1'b0;
    logic [1:0] rand_row = 2'd0;
    logic [1:0] rand_col = 2'd0;
    logic [1:0] phase;
    logic       is_started;
    logic       mole_valid;
    logic [1:0] mole_row;
    logic [1:0] mole_col;
    logic       hit_ack;
    logic [6:0] time_left;
    logic [9:0] hit_count;
    logic [6:0] miss_count;
    logic [3:0] level;

    int checks = 0;
    int failures = 0;

    mole_round_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .tick_sec(tick_sec),
        .tick_step(tick_step), .hit(hit), .rand_row(rand_row), .rand_col(rand_col),
        .phase(phase), .is_started(is_started), .mole_valid(mole_valid),
        .mole_row(mole_row), .mole_col(mole_col), .hit_ack(hit_ack),
        .time_left(time_left), .hit_count(hit_count), .miss_count(miss_count),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sec();
        tick_sec = 1'b1; cyc(); tick_sec = 1'b0;
    endtask

    task automatic pulse_step();
        tick_step = 1'b1; cyc(); tick_step = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1; cyc(); hit = 1'b0;
    endtask

    // GAP with GAP_TICKS=2: two steps drain it, then SPAWN, then UP.
    task automatic respawn();
        pulse_step(); pulse_step(); cyc(); cyc();
    endtask

    initial begin
        cyc(); cyc();
        check("rst_phase", 32'(phase), 0);
        check("rst_time", 32'(time_left), 60);
        check("rst_valid", 32'(mole_valid), 0);
        check("rst_started", 32'(is_started), 0);
        check("rst_hits", 32'(hit_count), 0);
        reset = 1'b1;
        cyc();

        // Start edge, ready countdown 3,2,1 then play.
        start = 1'b0;
        cyc();
        check("ready_phase", 32'(phase), 1);
        check("ready_t3", 32'(time_left), 3);
        cyc(); cyc();
        check("ready_hold", 32'(time_left), 3);
        pulse_sec();
        check("ready_t2", 32'(time_left), 2);
        pulse_sec();
        check("ready_t1", 32'(time_left), 1);
        rand_row = 2'd2; rand_col = 2'd1;
        pulse_sec();
        check("play_phase", 32'(phase), 2);
        check("play_started", 32'(is_started), 1);
        check("play_time", 32'(time_left), 60);
        check("spawn_valid0", 32'(mole_valid), 0);
        cyc();
        check("spawn_valid1", 32'(mole_valid), 1);
        check("spawn_pos", 32'({mole_row, mole_col}), 32'({2'd2, 2'd1}));

        // Life 20 at level 0: 19 steps keep the mole, 20th drops it.
        for (int i = 0; i < 19; i++) pulse_step();
        check("life20_up", 32'(mole_valid), 1);
        pulse_step();
        check("life20_down", 32'(mole_valid), 0);
        check("miss1", 32'(miss_count), 1);
        rand_row = 2'd1; rand_col = 2'd3;
        pulse_step(); pulse_step();
        check("gap_valid", 32'(mole_valid), 0);
        cyc(); cyc();
        check("respawn_valid", 32'(mole_valid), 1);
        check("respawn_pos", 32'({mole_row, mole_col}), 32'({2'd1, 2'd3}));

        // Hit handling, repeat-position bump, hit ignored in GAP.
        pulse_hit();
        check("hit_ack", 32'(hit_ack), 1);
        check("hit_cnt1", 32'(hit_count), 1);
        check("hit_valid", 32'(mole_valid), 0);
        cyc();
        check("hit_ack_clr", 32'(hit_ack), 0);
        pulse_hit();
        check("gap_hit_ack", 32'(hit_ack), 0);
        check("gap_hit_cnt", 32'(hit_count), 1);
        respawn();
        check("same_pos", 32'({mole_row, mole_col}), 32'({2'd1, 2'd0}));
        rand_row = 2'd3; rand_col = 2'd2;
        for (int i = 0; i < 4; i++) begin
            pulse_hit();
            respawn();
        end
        check("hit_cnt5", 32'(hit_count), 5);
        check("level1", 32'(level), 1);
        for (int i = 0; i < 17; i++) pulse_step();
        check("life18_up", 32'(mole_valid), 1);
        pulse_step();
        check("life18_down", 32'(mole_valid), 0);
        check("miss2", 32'(miss_count), 2);

        // Fifty more hits: level 11, life floored at 5.
        respawn();
        for (int i = 0; i < 50; i++) begin
            pulse_hit();
            respawn();
        end
        check("hit_cnt55", 32'(hit_count), 55);
        check("level11", 32'(level), 11);
        for (int i = 0; i < 4; i++) pulse_step();
        check("life5_up", 32'(mole_valid), 1);
        pulse_step();
        check("life5_down", 32'(mole_valid), 0);
        check("miss3", 32'(miss_count), 3);

        // Hit and final step in the same cycle: hit wins.
        respawn();
        for (int i = 0; i < 4; i++) pulse_step();
        hit = 1'b1; tick_step = 1'b1; cyc(); hit = 1'b0; tick_step = 1'b0;
        check("tie_hits", 32'(hit_count), 56);
        check("tie_miss", 32'(miss_count), 3);
        check("tie_valid", 32'(mole_valid), 0);

        // Misses 4..10; tenth ends the game.
        for (int k = 4; k <= 10; k++) begin
            respawn();
            for (int i = 0; i < 5; i++) pulse_step();
            if (k == 9) check("miss9_phase", 32'(phase), 2);
        end
        check("miss10", 32'(miss_count), 10);
        check("over_phase", 32'(phase), 3);
        check("over_started", 32'(is_started), 0);
        check("over_valid", 32'(mole_valid), 0);
        check("over_hold_hits", 32'(hit_count), 56);

        // Start still held low: no new event. Release and press again.
        cyc(); cyc();
        check("held_start", 32'(phase), 3);
        start = 1'b1; cyc();
        start = 1'b0; cyc();
        check("restart_phase", 32'(phase), 1);
        check("restart_hits", 32'(hit_count), 0);
        check("restart_miss", 32'(miss_count), 0);
        check("restart_level", 32'(level), 0);
        check("restart_time", 32'(time_left), 3);

        // Hit on the last game second: counted, game over.
        pulse_sec(); pulse_sec(); pulse_sec();
        cyc(); cyc();
        check("late_valid", 32'(mole_valid), 1);
        for (int i = 0; i < 59; i++) pulse_sec();
        check("late_time1", 32'(time_left), 1);
        check("late_phase2", 32'(phase), 2);
        hit = 1'b1; tick_sec = 1'b1; cyc(); hit = 1'b0; tick_sec = 1'b0;
        check("late_hits", 32'(hit_count), 1);
        check("late_ack", 32'(hit_ack), 1);
        check("late_phase3", 32'(phase), 3);
        check("late_time0", 32'(time_left), 0);
        check("late_valid0", 32'(mole_valid), 0);

        // Asynchronous reset in the middle of UP.
        start = 1'b1; cyc();
        start = 1'b0; cyc();
        pulse_sec(); pulse_sec(); pulse_sec();
        cyc(); cyc();
        pulse_hit();
        respawn();
        check("pre_rst_valid", 32'(mole_valid), 1);
        check("pre_rst_hits", 32'(hit_count), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_phase", 32'(phase), 0);
        check("arst_valid", 32'(mole_valid), 0);
        check("arst_time", 32'(time_left), 60);
        check("arst_hits", 32'(hit_count), 0);
        check("arst_started", 32'(is_started), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
